npu_img_row_loader: RTL
=======================

# npu_img_row_loader

AHB-Lite master that feeds the NPU from upstream. It accepts a byte-wide pixel stream from the camera/pre-processing path, buffers it in a small FIFO, and writes each pixel into the NPU RGB input memory over the NPU AHB slave port. After each complete row it writes the row-commit register. After the last row it polls the NPU status register and presents the predicted class.

## Interface
Parameters:
- MEM_BASE, 32'h0000_0000: AHB byte address of RGB input memory location 0.
- WRITE_ROW_ADDR, 32'h0000_2000: register address; any write pulses the NPU row-commit.
- THRSHLD_ADDR, 32'h0000_2004: register address for the row-start threshold, bits [5:0].
- STATUS_ADDR, 32'h0000_2008: status register; bit0 = npu_done, bits [8:4] = class predicted.
- ROW_BYTES, 64: bytes per row.
- NUM_ROWS, 64: rows per frame (at most 64).
- THRSHLD, 6'd4: value written to THRSHLD_ADDR at frame start.
- POLL_GAP, 8: idle cycles between status polls.
- FIFO_DEPTH, 16: pixel FIFO entries (power of two).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_valid_i  in  1  pixel valid.
- pix_ready_o  out  1  pixel accepted when valid & ready.
- pix_data_i  in  8  pixel byte.
- pix_sof_i  in  1  marks the first pixel of a frame.
- clr_err_i  in  1  clears err_o.
- busy_o  out  1  frame in progress (any state except IDLE).
- result_valid_o  out  1  one-cycle pulse; class_o is valid in that cycle.
- class_o  out  5  class from the last completed frame; held until the next result.
- err_o  out  1  sticky error flag.
- ahb_m_haddr_o  out  32  address.
- ahb_m_hwrite_o  out  1  1 = write.
- ahb_m_hsize_o  out  3  000 for pixel writes, 010 for register accesses.
- ahb_m_hburst_o  out  3  always 000 (SINGLE).
- ahb_m_htrans_o  out  2  10 (NONSEQ) in the address phase, otherwise 00.
- ahb_m_hwdata_o  out  32  write data.
- ahb_m_hready_i  in  1  slave ready.
- ahb_m_hresp_i  in  1  1 = ERROR.
- ahb_m_hrdata_i  in  32  read data.

## Operation
- FIFO:
  - Entries are 9 bits, {sof, data}.
  - pix_ready_o = !full && !rst.
  - Push on valid & ready. Pop only in the PIX_A address phase.
  - A simultaneous push and pop at full is impossible because ready is low; at empty, pop is gated by !empty.
- FSM states: IDLE, CFG_A, CFG_D, PIX_A, PIX_D, ROW_A, ROW_D, POLL_WAIT, POLL_A, POLL_D, DONE.
  - IDLE: if the FIFO head has sof=1, go to CFG_A and clear row/col. If the head has sof=0, pop and discard it (orphan pixel; err_o is not set).
  - CFG_A/CFG_D: word write of THRSHLD, zero-extended, to THRSHLD_ADDR.
  - PIX_A: requires FIFO !empty, otherwise stay and drive htrans=00. Pop and issue a byte write to MEM_BASE + row*ROW_BYTES + col.
  - PIX_D: drive hwdata = the byte replicated on all four lanes; hold until hready. On completion:
    - if col == ROW_BYTES-1: col = 0, go to ROW_A;
    - else col++ and go to PIX_A.
  - ROW_A/ROW_D: word write of 32'h1 to WRITE_ROW_ADDR. Then row++; if the old row == NUM_ROWS-1, go to POLL_A; else go to PIX_A.
  - POLL_A/POLL_D: word read of STATUS_ADDR; hrdata is sampled when hready=1 in the data phase. If bit0=1, latch class_o = hrdata[8:4] and go to DONE; else go to POLL_WAIT.
  - POLL_WAIT: count POLL_GAP cycles, then go to POLL_A.
  - DONE: pulse result_valid_o for one cycle, go to IDLE.
- Mid-frame sof: if a popped entry in PIX_A has sof=1 while row|col != 0:
  - set err_o;
  - reset row/col to 0 and write that pixel as pixel 0 of the new frame;
  - no threshold rewrite.
- hresp=1 in any data phase: set err_o, drop the transfer, go to IDLE. Remaining FIFO pixels are then discarded until the next sof.
- err_o is set by the events above and cleared by clr_err_i. A set event wins over a simultaneous clear.

## Timing
- Reset values: all AHB outputs 0 (htrans=00, hburst=000), busy_o=0, result_valid_o=0, class_o=0, err_o=0, FIFO empty, state IDLE.
- Reset mid-transfer forces htrans=00 immediately (asynchronous). This aborts the frame; no recovery is needed.
- Address phase lasts exactly one cycle with htrans=10. The next cycle is the data phase with htrans=00, repeated while hready=0. hwdata is valid for the whole data phase.
- With hready always 1:
  - a pixel costs 2 cycles;
  - a row costs 2*ROW_BYTES + 2 cycles;
  - the first address phase occurs 2 cycles after the sof pixel is pushed (IDLE→CFG_A on the cycle after the push).
- No pipelining of consecutive transfers: the next address phase never overlaps a data phase.

## Test plan
- Frame, ROW_BYTES=4, NUM_ROWS=2, hready=1, done on first poll with hrdata=32'h0000_0131:
  - writes THRSHLD to THRSHLD_ADDR;
  - 8 byte writes at MEM_BASE+0..7;
  - 32'h1 to WRITE_ROW_ADDR after bytes 3 and 7;
  - class_o=5'h13 with a one-cycle result_valid_o.
- hready held low 3 cycles in each pixel data phase: hwdata is stable, no extra address phases, each pixel takes 5 cycles.
- Poll returns bit0=0 twice, then 1: three reads, each separated by exactly POLL_GAP idle cycles.
- 20 pixels pushed back-to-back with hready=0: pix_ready_o drops after 16 accepted; no data is lost or reordered.
- hresp=1 on the 3rd pixel write: err_o=1, FSM returns to IDLE, the following sof=0 pixels are discarded; clr_err_i clears err_o.
- sof arrives at row 0, col 2: err_o=1 and that pixel is written to MEM_BASE+0.

Source files
------------

// File: rtl/npu_img_row_loader.sv
// AHB-Lite master: buffers a byte pixel stream in a small FIFO, writes each row into the
// NPU RGB input memory, commits rows, then polls NPU status and presents the predicted class.
module npu_img_row_loader #(
    parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
    parameter logic [31:0] WRITE_ROW_ADDR = 32'h0000_2000,
    parameter logic [31:0] THRSHLD_ADDR   = 32'h0000_2004,
    parameter logic [31:0] STATUS_ADDR    = 32'h0000_2008,
    parameter int          ROW_BYTES      = 64,
    parameter int          NUM_ROWS       = 64,
    parameter logic [5:0]  THRSHLD        = 6'd4,
    parameter int          POLL_GAP       = 8,
    parameter int          FIFO_DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    input  logic [7:0]  pix_data_i,
    input  logic        pix_sof_i,
    input  logic        clr_err_i,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [4:0]  class_o,
    output logic        err_o,
    output logic [31:0] ahb_m_haddr_o,
    output logic        ahb_m_hwrite_o,
    output logic [2:0]  ahb_m_hsize_o,
    output logic [2:0]  ahb_m_hburst_o,
    output logic [1:0]  ahb_m_htrans_o,
    output logic [31:0] ahb_m_hwdata_o,
    input  logic        ahb_m_hready_i,
    input  logic        ahb_m_hresp_i,
    input  logic [31:0] ahb_m_hrdata_i
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST_COL = 16'(ROW_BYTES - 1);
    localparam logic [15:0] LAST_ROW = 16'(NUM_ROWS - 1);
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
    localparam logic [1:0]  NONSEQ   = 2'b10;
    localparam logic [2:0]  SZ_WORD  = 3'b010;

    typedef enum logic [3:0] {
        IDLE, CFG_A, CFG_D, PIX_A, PIX_D, ROW_A, ROW_D, POLL_WAIT, POLL_A, POLL_D, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] row, row_nxt, col, col_nxt, cnt, cnt_nxt;
    logic        set_err, latch_class, latch_pix;
    logic [7:0]  pix_byte;
    logic        unused_rdata;

    // Pixel FIFO: entries are {sof, data}; pointers carry one wrap bit.
    logic [8:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop;
    logic [8:0]  head;

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pix_ready_o = !full && !rst;
    assign push        = pix_valid_i && pix_ready_o;
    assign head        = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)      fifo_mem[wr_ptr[AW-1:0]] <= {pix_sof_i, pix_data_i};
        if (latch_pix) pix_byte <= head[7:0];
    end

    assign busy_o         = (state != IDLE);
    assign ahb_m_hburst_o = 3'b000;
    assign unused_rdata   = ^{ahb_m_hrdata_i[31:9], ahb_m_hrdata_i[3:1]};

    always_comb begin
        state_nxt      = state;
        row_nxt        = row;
        col_nxt        = col;
        cnt_nxt        = cnt;
        pop            = 1'b0;
        set_err        = 1'b0;
        latch_class    = 1'b0;
        latch_pix      = 1'b0;
        result_valid_o = 1'b0;
        ahb_m_htrans_o = 2'b00;
        ahb_m_haddr_o  = 32'h0;
        ahb_m_hwrite_o = 1'b0;
        ahb_m_hsize_o  = 3'b000;
        ahb_m_hwdata_o = 32'h0;
        case (state)
            IDLE: begin
                // Only a start-of-frame pixel opens a frame; anything else is an orphan.
                if (!empty) begin
                    if (head[8]) begin
                        state_nxt = CFG_A;
                        row_nxt   = '0;
                        col_nxt   = '0;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            CFG_A: begin
                ahb_m_htrans_o = NONSEQ;
                ahb_m_haddr_o  = THRSHLD_ADDR;
                ahb_m_hwrite_o = 1'b1;
                ahb_m_hsize_o  = SZ_WORD;
                state_nxt      = CFG_D;
            end
            CFG_D: begin
                ahb_m_hwdata_o = {26'd0, THRSHLD};
                if (ahb_m_hresp_i) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else if (ahb_m_hready_i) begin
                    state_nxt = PIX_A;
                end
            end
            PIX_A: begin
                if (!empty) begin
                    pop            = 1'b1;
                    latch_pix      = 1'b1;
                    ahb_m_htrans_o = NONSEQ;
                    ahb_m_hwrite_o = 1'b1;
                    state_nxt      = PIX_D;
                    // A sof restarts the frame at pixel 0; mid-frame it is also an error.
                    if (head[8]) begin
                        ahb_m_haddr_o = MEM_BASE;
                        row_nxt       = '0;
                        col_nxt       = '0;
                        set_err       = (row != '0) || (col != '0);
                    end else begin
                        ahb_m_haddr_o = MEM_BASE + 32'(row) * 32'(ROW_BYTES) + 32'(col);
                    end
                end
            end
            PIX_D: begin
                ahb_m_hwdata_o = {4{pix_byte}};
                if (ahb_m_hresp_i) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else if (ahb_m_hready_i) begin
                    if (col == LAST_COL) begin
                        col_nxt   = '0;
                        state_nxt = ROW_A;
                    end else begin
                        col_nxt   = col + 16'd1;
                        state_nxt = PIX_A;
                    end
                end
            end
            ROW_A: begin
                ahb_m_htrans_o = NONSEQ;
                ahb_m_haddr_o  = WRITE_ROW_ADDR;
                ahb_m_hwrite_o = 1'b1;
                ahb_m_hsize_o  = SZ_WORD;
                state_nxt      = ROW_D;
            end
            ROW_D: begin
                ahb_m_hwdata_o = 32'h1;
                if (ahb_m_hresp_i) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else if (ahb_m_hready_i) begin
                    row_nxt   = row + 16'd1;
                    state_nxt = (row == LAST_ROW) ? POLL_A : PIX_A;
                end
            end
            POLL_A: begin
                ahb_m_htrans_o = NONSEQ;
                ahb_m_haddr_o  = STATUS_ADDR;
                ahb_m_hsize_o  = SZ_WORD;
                state_nxt      = POLL_D;
            end
            POLL_D: begin
                if (ahb_m_hresp_i) begin
                    set_err   = 1'b1;
                    state_nxt = IDLE;
                end else if (ahb_m_hready_i) begin
                    if (ahb_m_hrdata_i[0]) begin
                        latch_class = 1'b1;
                        state_nxt   = DONE;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = POLL_WAIT;
                    end
                end
            end
            POLL_WAIT: begin
                if (cnt == GAP_LAST) state_nxt = POLL_A;
                else                 cnt_nxt   = cnt + 16'd1;
            end
            DONE: begin
                result_valid_o = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            cnt     <= '0;
            class_o <= '0;
            err_o   <= 1'b0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            cnt   <= cnt_nxt;
            if (latch_class) class_o <= ahb_m_hrdata_i[8:4];
            // A new error event outranks a simultaneous clear request.
            if (set_err)        err_o <= 1'b1;
            else if (clr_err_i) err_o <= 1'b0;
        end
    end
endmodule
